// File: rtl/uart_link_controller.sv
// -----------------------------------------------------------------------------
// uart_link_controller
//
// Byte-level sequencer between the UART RX/TX engines and the ECG classifier
// core. Collects NUM_IN_WORDS received bytes into the core input buffer, pulses
// core_start, waits for core_done, then streams NUM_OUT_WORDS result bytes from
// the core output buffer to the UART transmitter. Tracks an inter-byte receive
// timeout and reports sticky error flags.
//
// Ports:
//   sysclk, rst_n        clock, asynchronous active-low reset
//   rx_valid/rx_data     received byte strobe and data
//   rx_frame_err         stop bit low on the byte strobed by rx_valid
//   tx_valid/tx_data     byte offered to UART TX, held until tx_ready
//   tx_ready             UART TX accepts the offered byte
//   in_we/in_addr/in_wdata   core input buffer write port
//   core_start           one-cycle start pulse to the core
//   core_done            core finished (level or pulse)
//   out_re/out_addr      core output buffer read port (data valid next cycle)
//   out_rdata            core output buffer read data
//   busy                 controller not idle
//   frame_done           one-cycle pulse after the last result byte is accepted
//   err                  sticky {overrun, timeout, framing}
//   err_clr              clears err (a same-cycle new error still sets)
// -----------------------------------------------------------------------------
module uart_link_controller #(
    parameter int  WIDTH         = 8,
    parameter int  NUM_IN_WORDS  = 1,
    parameter int  NUM_OUT_WORDS = 32,
    parameter int  RX_TIMEOUT    = 13750,
    localparam int IN_AW  = $clog2(NUM_IN_WORDS  > 2 ? NUM_IN_WORDS  : 2),
    localparam int OUT_AW = $clog2(NUM_OUT_WORDS > 2 ? NUM_OUT_WORDS : 2)
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [WIDTH-1:0]  rx_data,
    input  logic              rx_frame_err,
    output logic              tx_valid,
    output logic [WIDTH-1:0]  tx_data,
    input  logic              tx_ready,
    output logic              in_we,
    output logic [IN_AW-1:0]  in_addr,
    output logic [WIDTH-1:0]  in_wdata,
    output logic              core_start,
    input  logic              core_done,
    output logic [OUT_AW-1:0] out_addr,
    output logic              out_re,
    input  logic [WIDTH-1:0]  out_rdata,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        err,
    input  logic              err_clr
);

    localparam int TMR_W = $clog2(RX_TIMEOUT + 1);

    localparam logic [IN_AW-1:0]  LAST_IN  = IN_AW'(NUM_IN_WORDS - 1);
    localparam logic [OUT_AW-1:0] LAST_OUT = OUT_AW'(NUM_OUT_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RX_TIMEOUT - 1);

    localparam int ERR_FRAMING = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        WAIT_CORE,
        FETCH,
        LOAD,
        SEND
    } state_t;

    state_t              state, state_d;
    logic [IN_AW-1:0]    in_cnt, in_cnt_d;
    logic [OUT_AW-1:0]   rd_ptr, rd_ptr_d;
    logic [TMR_W-1:0]    timer, timer_d;

    logic                tx_valid_d;
    logic [WIDTH-1:0]    tx_data_d;
    logic                in_we_d;
    logic [IN_AW-1:0]    in_addr_d;
    logic [WIDTH-1:0]    in_wdata_d;
    logic                core_start_d;
    logic [OUT_AW-1:0]   out_addr_d;
    logic                out_re_d;
    logic                busy_d;
    logic                frame_done_d;
    logic [2:0]          err_set;
    logic [2:0]          err_d;

    // Every output is a flop; this block only computes their next values.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state;
        in_cnt_d     = in_cnt;
        rd_ptr_d     = rd_ptr;
        timer_d      = timer;
        tx_valid_d   = tx_valid;
        tx_data_d    = tx_data;
        in_we_d      = 1'b0;
        in_addr_d    = in_addr;
        in_wdata_d   = in_wdata;
        core_start_d = 1'b0;
        out_addr_d   = out_addr;
        out_re_d     = 1'b0;
        frame_done_d = 1'b0;
        err_set      = '0;

        case (state)
            IDLE: begin
                timer_d = '0;
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        err_set[ERR_FRAMING] = 1'b1;
                    end else begin
                        in_we_d    = 1'b1;
                        in_addr_d  = '0;
                        in_wdata_d = rx_data;
                        in_cnt_d   = IN_AW'(1);
                        state_d    = (NUM_IN_WORDS == 1) ? START : RECV;
                    end
                end
            end

            RECV: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (rx_frame_err) begin
                        err_set[ERR_FRAMING] = 1'b1;
                        state_d              = IDLE;
                    end else begin
                        in_we_d    = 1'b1;
                        in_addr_d  = in_cnt;
                        in_wdata_d = rx_data;
                        in_cnt_d   = in_cnt + IN_AW'(1);
                        if (in_cnt == LAST_IN) begin
                            state_d = START;
                        end
                    end
                end else if (timer == TMR_LAST) begin
                    // Partial frame is abandoned; the buffer is simply
                    // overwritten by the next frame.
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end

            START: begin
                // A byte arriving here cannot be stored either, so it is
                // flagged the same way as during the core/transmit phase.
                if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
                core_start_d = 1'b1;
                state_d      = WAIT_CORE;
            end

            WAIT_CORE: begin
                if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
                if (core_done) begin
                    // Read strobe is launched on entry so it is presented
                    // during FETCH and the buffer data is ready in LOAD.
                    rd_ptr_d   = '0;
                    out_addr_d = '0;
                    out_re_d   = 1'b1;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
                state_d = LOAD;
            end

            LOAD: begin
                if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
                tx_data_d  = out_rdata;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end

            SEND: begin
                if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (rd_ptr == LAST_OUT) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr + OUT_AW'(1);
                        out_addr_d = rd_ptr + OUT_AW'(1);
                        out_re_d   = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks state exactly.
        busy_d = (state_d != IDLE);
        // Clear first, then OR in new events: a same-cycle error survives.
        err_d  = (err_clr ? 3'b000 : err) | err_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_cnt     <= '0;
            rd_ptr     <= '0;
            timer      <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            in_we      <= 1'b0;
            in_addr    <= '0;
            in_wdata   <= '0;
            core_start <= 1'b0;
            out_addr   <= '0;
            out_re     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= '0;
        end else begin
            state      <= state_d;
            in_cnt     <= in_cnt_d;
            rd_ptr     <= rd_ptr_d;
            timer      <= timer_d;
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            in_we      <= in_we_d;
            in_addr    <= in_addr_d;
            in_wdata   <= in_wdata_d;
            core_start <= core_start_d;
            out_addr   <= out_addr_d;
            out_re     <= out_re_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_link_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_link_controller
//
// Directed bench for uart_link_controller. Instance dut_a uses the default
// parameters (1 input byte, 32 result bytes); instance dut_b collects 4 input
// bytes. Each has a small synchronous output-buffer model holding addr ^ 0x3C.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_link_controller;

    localparam int T_OUT = 13750;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       tx_ready;
    logic       core_done;
    logic       err_clr;

    // dut_a signals
    logic       rx_valid_a, tx_valid_a, in_we_a, core_start_a, out_re_a;
    logic       busy_a, frame_done_a;
    logic [7:0] tx_data_a, in_wdata_a, out_rdata_a;
    logic [0:0] in_addr_a;
    logic [4:0] out_addr_a;
    logic [2:0] err_a;

    // dut_b signals
    logic       rx_valid_b, tx_valid_b, in_we_b, core_start_b, out_re_b;
    logic       busy_b, frame_done_b;
    logic [7:0] tx_data_b, in_wdata_b, out_rdata_b;
    logic [1:0] in_addr_b;
    logic [4:0] out_addr_b;
    logic [2:0] err_b;

    int checks = 0;
    int errors = 0;
    int cs_cnt_b = 0;

    uart_link_controller dut_a (
        .sysclk(sysclk), .rst_n(rst_n),
        .rx_valid(rx_valid_a), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready),
        .in_we(in_we_a), .in_addr(in_addr_a), .in_wdata(in_wdata_a),
        .core_start(core_start_a), .core_done(core_done),
        .out_addr(out_addr_a), .out_re(out_re_a), .out_rdata(out_rdata_a),
        .busy(busy_a), .frame_done(frame_done_a), .err(err_a), .err_clr(err_clr)
    );

    uart_link_controller #(.NUM_IN_WORDS(4)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n),
        .rx_valid(rx_valid_b), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready),
        .in_we(in_we_b), .in_addr(in_addr_b), .in_wdata(in_wdata_b),
        .core_start(core_start_b), .core_done(core_done),
        .out_addr(out_addr_b), .out_re(out_re_b), .out_rdata(out_rdata_b),
        .busy(busy_b), .frame_done(frame_done_b), .err(err_b), .err_clr(err_clr)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Output buffer models: synchronous read, word i holds i ^ 0x3C.
    always @(posedge sysclk) begin
        if (out_re_a) out_rdata_a <= {3'b000, out_addr_a} ^ 8'h3C;
        if (out_re_b) out_rdata_b <= {3'b000, out_addr_b} ^ 8'h3C;
        if (core_start_b) cs_cnt_b <= cs_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one received byte for one cycle on the selected instance.
    task automatic send_rx(input bit to_b, input logic [7:0] data, input logic ferr);
        rx_data      = data;
        rx_frame_err = ferr;
        if (to_b) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
        @(negedge sysclk);
        rx_valid_a   = 1'b0;
        rx_valid_b   = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic pulse_core_done();
        core_done = 1'b1;
        @(negedge sysclk);
        core_done = 1'b0;
    endtask

    // Accepts dut_a result bytes, checking each against addr ^ 0x3C.
    // Optionally stalls tx_ready on byte stall_idx, or stops (un-acked) when
    // byte stop_at is offered. Returns at the negedge where frame_done shows.
    task automatic run_tx(input int stall_idx, input int stall_len, input int stop_at,
                          output int n_bytes, output int n_fd, output bit stable_ok);
        int         stalled;
        logic [7:0] held;
        bit         done;
        n_bytes   = 0;
        n_fd      = 0;
        stable_ok = 1'b1;
        stalled   = 0;
        held      = '0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (frame_done_a) begin
                n_fd++;
                done = 1'b1;
            end else if (tx_valid_a) begin
                if (n_bytes == stop_at) begin
                    tx_ready = 1'b0;
                    done     = 1'b1;
                end else if (n_bytes == stall_idx && stalled < stall_len) begin
                    tx_ready = 1'b0;
                    if (stalled == 0) held = tx_data_a;
                    else if (tx_data_a !== held) stable_ok = 1'b0;
                    stalled++;
                end else begin
                    check("tx_byte", tx_data_a, 8'(n_bytes) ^ 8'h3C);
                    tx_ready = 1'b1;
                    n_bytes++;
                end
            end else begin
                if (stalled > 0 && stalled < stall_len) stable_ok = 1'b0;
                tx_ready = 1'b1;
            end
            if (!done) @(negedge sysclk);
        end
    endtask

    task automatic full_frame_a(input string tag, input int stall_idx, input int stall_len);
        int nb, nf;
        bit st;
        run_tx(stall_idx, stall_len, -1, nb, nf, st);
        check({tag, "_bytes"}, nb, 32);
        check({tag, "_frame_done"}, nf, 1);
        check({tag, "_idle_busy"}, busy_a, 1'b0);
        check({tag, "_stable"}, st, 1'b1);
        @(negedge sysclk);
        check({tag, "_fd_single"}, frame_done_a, 1'b0);
    endtask

    initial begin
        int nb, nf;
        bit st;
        rst_n        = 1'b0;
        rx_valid_a   = 1'b0;
        rx_valid_b   = 1'b0;
        rx_data      = '0;
        rx_frame_err = 1'b0;
        tx_ready     = 1'b1;
        core_done    = 1'b0;
        err_clr      = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);

        // Reset state: every dut_a output is zero.
        check("reset_outputs_a",
              {tx_valid_a, tx_data_a, in_we_a, in_addr_a, in_wdata_a, core_start_a,
               out_addr_a, out_re_a, busy_a, frame_done_a, err_a}, 32'd0);
        check("reset_b", {busy_b, err_b, in_we_b, core_start_b}, 32'd0);

        // Frame 1: single input byte, then 32 results with tx_ready high.
        send_rx(1'b0, 8'hA5, 1'b0);
        check("in_we", in_we_a, 1'b1);
        check("in_addr", in_addr_a, 1'b0);
        check("in_wdata", in_wdata_a, 8'hA5);
        check("busy_rx", busy_a, 1'b1);
        check("start_early", core_start_a, 1'b0);
        @(negedge sysclk);
        check("core_start", core_start_a, 1'b1);
        check("in_we_pulse", in_we_a, 1'b0);
        @(negedge sysclk);
        check("core_start_pulse", core_start_a, 1'b0);
        check("busy_wait", busy_a, 1'b1);
        pulse_core_done();
        check("fetch_re", out_re_a, 1'b1);
        check("fetch_addr", out_addr_a, 5'd0);
        @(negedge sysclk);
        check("lat_2", tx_valid_a, 1'b0);
        @(negedge sysclk);
        check("lat_3", tx_valid_a, 1'b1);
        full_frame_a("f1", -1, 0);

        // Framing error in IDLE: nothing written, err = framing.
        send_rx(1'b0, 8'h5A, 1'b1);
        check("ferr_no_we", in_we_a, 1'b0);
        check("ferr_err", err_a, 3'b001);
        check("ferr_idle", busy_a, 1'b0);
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
        check("err_clr_a", err_a, 3'b000);

        // Frame 2: overrun during WAIT_CORE, stall 100 cycles on byte 5.
        send_rx(1'b0, 8'h77, 1'b0);
        @(negedge sysclk);
        send_rx(1'b0, 8'h99, 1'b0);
        check("overrun_err", err_a, 3'b100);
        check("overrun_no_we", in_we_a, 1'b0);
        pulse_core_done();
        full_frame_a("f2", 5, 100);
        check("overrun_sticky", err_a, 3'b100);

        // err_clr together with a new framing error: the new bit survives.
        err_clr = 1'b1;
        send_rx(1'b0, 8'h00, 1'b1);
        err_clr = 1'b0;
        check("set_wins", err_a, 3'b001);

        // Frame 3: reset while byte 10 is offered.
        send_rx(1'b0, 8'h01, 1'b0);
        @(negedge sysclk);
        pulse_core_done();
        run_tx(-1, 0, 10, nb, nf, st);
        check("pre_rst_byte", tx_data_a, 8'h36);
        check("pre_rst_valid", tx_valid_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              {tx_valid_a, tx_data_a, in_we_a, in_addr_a, in_wdata_a, core_start_a,
               out_addr_a, out_re_a, busy_a, frame_done_a, err_a}, 32'd0);
        @(negedge sysclk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge sysclk);

        // Frame 4: full frame after reset restarts from byte 0.
        send_rx(1'b0, 8'h02, 1'b0);
        @(negedge sysclk);
        pulse_core_done();
        full_frame_a("f4", -1, 0);

        // dut_b: two bytes then silence -> timeout exactly T_OUT cycles later.
        send_rx(1'b1, 8'h11, 1'b0);
        check("b_addr0", in_addr_b, 2'd0);
        send_rx(1'b1, 8'h22, 1'b0);
        check("b_addr1", {in_we_b, in_addr_b, in_wdata_b}, {1'b1, 2'd1, 8'h22});
        repeat (T_OUT - 1) @(negedge sysclk);
        check("b_tmo_early", {busy_b, err_b}, {1'b1, 3'b000});
        @(negedge sysclk);
        check("b_tmo_err", err_b, 3'b010);
        check("b_tmo_idle", busy_b, 1'b0);
        check("b_no_start", cs_cnt_b, 0);
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
        check("b_err_clr", err_b, 3'b000);

        // dut_b: framing error mid-frame aborts to IDLE without writing.
        send_rx(1'b1, 8'h33, 1'b0);
        send_rx(1'b1, 8'h44, 1'b1);
        check("b_ferr", {in_we_b, busy_b, err_b}, {1'b0, 1'b0, 3'b001});

        // dut_b: complete 4-byte frame -> last write at addr 3, then start.
        send_rx(1'b1, 8'hA0, 1'b0);
        send_rx(1'b1, 8'hA1, 1'b0);
        send_rx(1'b1, 8'hA2, 1'b0);
        check("b_no_start_yet", core_start_b, 1'b0);
        send_rx(1'b1, 8'hA3, 1'b0);
        check("b_last_write", {in_we_b, in_addr_b, in_wdata_b}, {1'b1, 2'd3, 8'hA3});
        check("b_start_early", core_start_b, 1'b0);
        @(negedge sysclk);
        check("b_start", core_start_b, 1'b1);
        check("b_start_count", cs_cnt_b, 0);
        @(negedge sysclk);
        check("b_start_count1", cs_cnt_b, 1);
        check("b_busy", busy_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
